// File: rtl/seq_hit_display_pkg.sv
// Shared constants for the hit-count display stage: segment codes for the
// 7-segment pad bus (detector bit encoding) and the display FSM state encoding.
package seq_hit_display_pkg;

  localparam logic [7:0] SEG_DASH = 8'h02;
  localparam logic [7:0] SEG_ALL  = 8'hFF;
  localparam logic [7:0] SEG_OFF  = 8'h00;

  localparam logic [7:0] SEG_D0 = 8'hFD;
  localparam logic [7:0] SEG_D1 = 8'hC1;
  localparam logic [7:0] SEG_D2 = 8'h6F;
  localparam logic [7:0] SEG_D3 = 8'hE7;
  localparam logic [7:0] SEG_D4 = 8'hD3;
  localparam logic [7:0] SEG_D5 = 8'hB7;
  localparam logic [7:0] SEG_D6 = 8'hBF;
  localparam logic [7:0] SEG_D7 = 8'hE1;
  localparam logic [7:0] SEG_D8 = 8'hFF;
  localparam logic [7:0] SEG_D9 = 8'hF7;

  // Encoding 2'd3 is unused; the FSM treats it as a fault and returns to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLASH = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

endpackage

// File: rtl/seq_hit_display_bcd_to_seg7.sv
// bcd_to_seg7: purely combinational 4-bit BCD to 8-bit segment code.
// Non-BCD inputs (10..15) blank the display.
module bcd_to_seg7
  import seq_hit_display_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [7:0] seg_o
);

  // Digit lookup; anything outside 0..9 shows nothing.
  always_comb begin
    seg_o = SEG_OFF;
    case (bcd_i)
      4'd0:    seg_o = SEG_D0;
      4'd1:    seg_o = SEG_D1;
      4'd2:    seg_o = SEG_D2;
      4'd3:    seg_o = SEG_D3;
      4'd4:    seg_o = SEG_D4;
      4'd5:    seg_o = SEG_D5;
      4'd6:    seg_o = SEG_D6;
      4'd7:    seg_o = SEG_D7;
      4'd8:    seg_o = SEG_D8;
      4'd9:    seg_o = SEG_D9;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seq_hit_display.sv
// seq_hit_display: counts detector hits modulo 10 and drives the segment bus.
// Shows '-' until the first hit, flashes '8.' for HOLD_CYCLES enabled cycles
// after every hit, then shows the BCD count.
// Build option: define SEQ_HIT_FLASH_EN to include the FLASH state and hold
// timer; without it a hit goes straight to showing the new digit.
//
// Handshake: hit_i is a single-cycle strobe with no back-pressure; every
// enabled edge with hit_i=1 and clr_i=0 is one accepted hit. Outputs are
// decoded from registers only, so nothing combinational reaches uo_out.
module seq_hit_display
  import seq_hit_display_pkg::*;
#(
  parameter int HOLD_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       hit_i,
  input  logic       clr_i,
  output logic [7:0] seg_o,
  output logic [3:0] count_o,
  output logic       ovf_o,
  output logic [1:0] state_o
);

  state_t     state_q, state_d;
  logic [3:0] count_q, count_d;
  logic       ovf_q, ovf_d;
  logic [7:0] digit_seg;

`ifdef SEQ_HIT_FLASH_EN
  localparam int TW = $clog2(HOLD_CYCLES + 1);
  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
  logic [TW-1:0] timer_q, timer_d;
`else
  // HOLD_CYCLES has no effect without the flash window.
  logic unused_hold;
  assign unused_hold = ^HOLD_CYCLES;
`endif

  // Next-state, counter, overflow and hold-timer logic; clear beats hit.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ovf_d   = ovf_q;
`ifdef SEQ_HIT_FLASH_EN
    timer_d = timer_q;
`endif
    if (clr_i) begin
      state_d = ST_IDLE;
      count_d = 4'd0;
      ovf_d   = 1'b0;
`ifdef SEQ_HIT_FLASH_EN
      timer_d = '0;
`endif
    end else if (state_q != ST_IDLE && state_q != ST_FLASH && state_q != ST_SHOW) begin
      state_d = ST_IDLE;
    end else if (hit_i) begin
      if (count_q >= 4'd9) begin
        count_d = 4'd0;
        ovf_d   = 1'b1;
      end else begin
        count_d = count_q + 4'd1;
      end
`ifdef SEQ_HIT_FLASH_EN
      state_d = ST_FLASH;
      timer_d = HOLD_LOAD;
`else
      state_d = ST_SHOW;
`endif
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
`ifdef SEQ_HIT_FLASH_EN
        ST_FLASH: begin
          if (timer_q == '0) begin
            state_d = ST_SHOW;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
`endif
        ST_SHOW: state_d = ST_SHOW;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State registers; ena=0 freezes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      count_q <= 4'd0;
      ovf_q   <= 1'b0;
`ifdef SEQ_HIT_FLASH_EN
      timer_q <= '0;
`endif
    end else if (ena) begin
      state_q <= state_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
`ifdef SEQ_HIT_FLASH_EN
      timer_q <= timer_d;
`endif
    end
  end

  bcd_to_seg7 u_bcd_to_seg7 (
    .bcd_i (count_q),
    .seg_o (digit_seg)
  );

  // Segment bus selection from the registered state.
  always_comb begin
    seg_o = SEG_DASH;
    case (state_q)
      ST_IDLE:  seg_o = SEG_DASH;
      ST_FLASH: seg_o = SEG_ALL;
      ST_SHOW:  seg_o = digit_seg;
      default:  seg_o = SEG_DASH;
    endcase
  end

  assign count_o = count_q;
  assign ovf_o   = ovf_q;
  assign state_o = state_q;

endmodule
